// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: jump codes and reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

    // Jump codes driven by the controller; codes 5..7 are unused and act as none
    typedef enum logic [2:0] {
        JUMP_NONE = 3'b000,
        JUMP_J    = 3'b001,
        JUMP_JAL  = 3'b010,
        JUMP_JR   = 3'b011,
        JUMP_JALR = 3'b100
    } jump_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Branch displacement: signed 16-bit word offset turned into a byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_npc.sv
// Next-PC selector: jump > register jump > taken branch > sequential.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to use the result.
module fetch_unit_npc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [2:0]  jump,
    input  logic        ValidBr,
    output logic [31:0] npc,
    output logic        misalign
);

    // Opcode bits are not needed to form any target
    logic w_unused_opcode;
    assign w_unused_opcode = ^instr[31:26];

    // Select the next PC; unused jump codes fall through to branch/sequential
    always_comb begin
        npc      = pc + 32'd4;
        misalign = 1'b0;
        case (jump)
            JUMP_J, JUMP_JAL: begin
                npc = {pc[31:28], instr[25:0], 2'b00};
            end
            JUMP_JR, JUMP_JALR: begin
                npc      = {rs_data[31:2], 2'b00};
                misalign = |rs_data[1:0];
            end
            default: begin
                if (ValidBr) begin
                    npc = pc + branch_offset(instr[15:0]);
                end
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, IR, fetch counter and sticky misaligned-target flag.
// Latency: registers update on the same edge as their enable; im_addr/link follow pc combinationally.
// Backpressure: none; PCWr/IRWr from the controller are the only stalls.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_AW    = 10
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWr,
    input  logic             IRWr,
    input  logic             ValidBr,
    input  logic [2:0]       jump,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      im_rdata,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic [31:0]      link,
    output logic [31:0]      instr_cnt,
    output logic             pc_err
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_cnt;
    logic        r_err;
    logic [31:0] w_npc;
    logic        w_misalign;

    fetch_unit_npc u_npc (
        .pc       (r_pc),
        .instr    (r_instr),
        .rs_data  (rs_data),
        .jump     (jump),
        .ValidBr  (ValidBr),
        .npc      (w_npc),
        .misalign (w_misalign)
    );

    // PC/IR/counter/flag update; reset wins over every enable on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= PC_RESET;
            r_instr <= 32'd0;
            r_cnt   <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (PCWr) begin
                r_pc <= w_npc;
            end
            if (IRWr) begin
                r_instr <= im_rdata;
                r_cnt   <= r_cnt + 32'd1;
            end
            // Only a committed jr/jalr to a misaligned target raises the flag
            if (PCWr && w_misalign) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pc        = r_pc;
    assign instr     = r_instr;
    assign instr_cnt = r_cnt;
    assign pc_err    = r_err;
    assign link      = r_pc;
    assign im_addr   = r_pc[IM_AW+1:2];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, PCWr, IRWr, ValidBr;
    logic [2:0]  jump;
    logic [31:0] rs_data, im_rdata;
    logic [9:0]  im_addr;
    logic [31:0] pc, instr, link, instr_cnt;
    logic        pc_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference state
    logic [31:0] m_pc, m_instr, m_cnt;
    logic        m_err;

    fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .PCWr      (PCWr),
        .IRWr      (IRWr),
        .ValidBr   (ValidBr),
        .jump      (jump),
        .rs_data   (rs_data),
        .im_rdata  (im_rdata),
        .im_addr   (im_addr),
        .pc        (pc),
        .instr     (instr),
        .link      (link),
        .instr_cnt (instr_cnt),
        .pc_err    (pc_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_npc(input logic [31:0] cur_pc, input logic [31:0] ir,
                                            input logic [31:0] rs, input logic [2:0] j,
                                            input logic br);
        int off;
        if (j == 3'd1 || j == 3'd2) return (cur_pc & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 4);
        if (j == 3'd3 || j == 3'd4) return rs & ~32'h3;
        if (br) begin
            off = int'($signed(ir[15:0]));
            return cur_pc + 32'(off * 4);
        end
        return cur_pc + 32'd4;
    endfunction

    // One clock edge; the model advances from the inputs present before the edge
    task automatic tick();
        logic [31:0] n_pc, n_instr, n_cnt;
        logic        n_err;
        if (rst) begin
            n_pc = 32'h0000_3000; n_instr = 32'd0; n_cnt = 32'd0; n_err = 1'b0;
        end else begin
            n_pc    = PCWr ? ref_npc(m_pc, m_instr, rs_data, jump, ValidBr) : m_pc;
            n_instr = IRWr ? im_rdata : m_instr;
            n_cnt   = IRWr ? m_cnt + 32'd1 : m_cnt;
            n_err   = m_err | (PCWr && (jump == 3'd3 || jump == 3'd4) && (rs_data % 4 != 0));
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_cnt = n_cnt; m_err = n_err;
    endtask

    task automatic idle();
        rst = 1'b0; PCWr = 1'b0; IRWr = 1'b0; ValidBr = 1'b0; jump = 3'd0;
        rs_data = 32'd0; im_rdata = 32'd0;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] a);
        idle(); rs_data = a; jump = 3'd3; PCWr = 1'b1; tick(); idle();
    endtask

    task automatic load_ir(input logic [31:0] w);
        idle(); im_rdata = w; IRWr = 1'b1; tick(); idle();
    endtask

    task automatic fetch(input logic [31:0] w);
        idle(); im_rdata = w; IRWr = 1'b1; PCWr = 1'b1; tick(); idle();
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++; if (pc !== 32'h3000) $display("FAIL reset_pc: got %h want %h", pc, 32'h3000); else pass_cnt++;
        chk_cnt++; if (instr !== 32'd0) $display("FAIL reset_instr: got %h want 0", instr); else pass_cnt++;
        chk_cnt++; if (instr_cnt !== 32'd0 || pc_err !== 1'b0)
            $display("FAIL reset_cnt_err: got cnt=%h err=%b want 0/0", instr_cnt, pc_err); else pass_cnt++;
        chk_cnt++; if (im_addr !== 10'h000 || link !== 32'h3000)
            $display("FAIL reset_addr_link: got addr=%h link=%h want 000/3000", im_addr, link); else pass_cnt++;
    endtask

    task automatic test_fetch();
        do_reset();
        fetch(32'hAAAA_0001);
        chk_cnt++; if (pc !== 32'h3004 || im_addr !== 10'h001)
            $display("FAIL fetch1: got pc=%h addr=%h want 3004/001", pc, im_addr); else pass_cnt++;
        fetch(32'hBBBB_0002);
        chk_cnt++; if (pc !== 32'h3008) $display("FAIL fetch2: got %h want 3008", pc); else pass_cnt++;
        fetch(32'hCCCC_0003);
        chk_cnt++; if (pc !== 32'h300C || instr !== 32'hCCCC_0003 || instr_cnt !== 32'd3)
            $display("FAIL fetch3: got pc=%h ir=%h cnt=%0d want 300c/cccc0003/3", pc, instr, instr_cnt);
        else pass_cnt++;
        // IR write without PC write
        load_ir(32'h1234_5678);
        chk_cnt++; if (pc !== 32'h300C || instr !== 32'h1234_5678 || instr_cnt !== 32'd4)
            $display("FAIL ir_only: got pc=%h ir=%h cnt=%0d want 300c/12345678/4", pc, instr, instr_cnt);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        set_pc(32'h3010);
        load_ir(32'h1000_FFFE);
        ValidBr = 1'b1; PCWr = 1'b1; tick(); idle();
        chk_cnt++; if (pc !== 32'h3008) $display("FAIL branch_back: got %h want 3008", pc); else pass_cnt++;
        set_pc(32'h3010);
        ValidBr = 1'b0; PCWr = 1'b0; tick();
        chk_cnt++; if (pc !== 32'h3010) $display("FAIL branch_hold: got %h want 3010", pc); else pass_cnt++;
    endtask

    task automatic test_jump();
        set_pc(32'h3004);
        load_ir(32'h0C00_0C10);
        jump = 3'd2; PCWr = 1'b1; #1;
        chk_cnt++; if (link !== 32'h3004) $display("FAIL jal_link: got %h want 3004", link); else pass_cnt++;
        tick(); idle();
        chk_cnt++; if (pc !== 32'h3040) $display("FAIL jal_pc: got %h want 3040", pc); else pass_cnt++;
    endtask

    task automatic test_jr_misalign();
        do_reset();
        rs_data = 32'h0000_3026; jump = 3'd3; PCWr = 1'b1; tick(); idle();
        chk_cnt++; if (pc !== 32'h3024 || pc_err !== 1'b1)
            $display("FAIL jr_misalign: got pc=%h err=%b want 3024/1", pc, pc_err); else pass_cnt++;
        fetch(32'h0); fetch(32'h0);
        chk_cnt++; if (pc_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", pc_err); else pass_cnt++;
        do_reset();
        chk_cnt++; if (pc_err !== 1'b0) $display("FAIL err_clear: got %b want 0", pc_err); else pass_cnt++;
    endtask

    task automatic test_conflict();
        do_reset();
        load_ir(32'h0000_0100);
        jump = 3'd1; ValidBr = 1'b1; PCWr = 1'b1; tick(); idle();
        chk_cnt++; if (pc !== 32'h0000_0400) $display("FAIL jump_wins: got %h want 00000400", pc); else pass_cnt++;
        jump = 3'd7; PCWr = 1'b1; tick(); idle();
        chk_cnt++; if (pc !== 32'h0000_0404) $display("FAIL jump7_seq: got %h want 00000404", pc); else pass_cnt++;
        set_pc(32'hFFFF_FFFC);
        load_ir(32'h1000_0001);
        ValidBr = 1'b1; PCWr = 1'b1; tick(); idle();
        chk_cnt++; if (pc !== 32'h0000_0000) $display("FAIL branch_wrap: got %h want 00000000", pc); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        fetch(32'h5555_5555);
        rst = 1'b1; PCWr = 1'b1; IRWr = 1'b1; im_rdata = 32'hDEAD_BEEF; tick(); idle();
        chk_cnt++; if (pc !== 32'h3000 || instr !== 32'd0 || instr_cnt !== 32'd0)
            $display("FAIL reset_mid: got pc=%h ir=%h cnt=%0d want 3000/0/0", pc, instr, instr_cnt);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            PCWr     = $urandom_range(0, 1);
            IRWr     = $urandom_range(0, 1);
            ValidBr  = $urandom_range(0, 1);
            jump     = 3'($urandom_range(0, 7));
            rs_data  = $urandom;
            if ($urandom_range(0, 15) != 0) rs_data[1:0] = 2'b00;
            im_rdata = $urandom;
            tick();
            chk_cnt++; if (pc !== m_pc || im_addr !== m_pc[11:2] || link !== m_pc)
                $display("FAIL rnd_pc[%0d]: got pc=%h addr=%h link=%h want %h", i, pc, im_addr, link, m_pc);
            else pass_cnt++;
            chk_cnt++; if (instr !== m_instr || instr_cnt !== m_cnt || pc_err !== m_err)
                $display("FAIL rnd_state[%0d]: got ir=%h cnt=%h err=%b want %h/%h/%b",
                         i, instr, instr_cnt, pc_err, m_instr, m_cnt, m_err);
            else pass_cnt++;
        end
        idle();
    endtask

    initial begin
        idle();
        m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
        #1;
        test_reset();
        test_fetch();
        test_branch();
        test_jump();
        test_jr_misalign();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multicycle CPU. It holds the program counter (PC) and the instruction register (IR), drives the instruction-memory address, and latches the fetched word. It computes the next PC for sequential, branch and jump flow. It sits directly upstream of the controller: it supplies `instr` and consumes the controller's `PCWr`, `IRWr`, `ValidBr` and `jump` outputs.

## Interface
Parameters:
- `PC_RESET`, default 32'h0000_3000: PC value after reset.
- `IM_AW`, default 10: instruction-memory word-address width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `PCWr`  in  1  PC write enable from the controller.
- `IRWr`  in  1  IR write enable from the controller.
- `ValidBr`  in  1  branch taken (already qualified by the compare result).
- `jump`  in  3  jump code: 000 none, 001 j, 010 jal, 011 jr, 100 jalr.
- `rs_data`  in  32  GPR[rs], used as the jr/jalr target.
- `im_rdata`  in  32  instruction-memory read data (asynchronous read of `im_addr`).
- `im_addr`  out  IM_AW  word address, equal to `pc[IM_AW+1:2]`.
- `pc`  out  32  current PC.
- `instr`  out  32  IR contents.
- `link`  out  32  return address for jal/jalr; equals `pc`.
- `instr_cnt`  out  32  count of IR writes.
- `pc_err`  out  1  sticky flag: misaligned jr/jalr target seen.

## Operation
- Reset (`rst`=1 at a clock edge): `pc`=PC_RESET, `instr`=0 (nop), `instr_cnt`=0, `pc_err`=0. Therefore `link`=PC_RESET and `im_addr`=PC_RESET[IM_AW+1:2]. Reset overrides every other input on the same edge.
- IR: when `IRWr`=1, `instr` <= `im_rdata`. Otherwise it holds.
- Counter: when `IRWr`=1, `instr_cnt` <= `instr_cnt`+1, wrapping modulo 2^32.
- PC: when `PCWr`=1, `pc` <= npc. Otherwise it holds. npc is chosen by this priority:
  1. `jump` = 001 or 010: {pc[31:28], instr[25:0], 2'b00}.
  2. `jump` = 011 or 100: {rs_data[31:2], 2'b00}. If `rs_data[1:0]` ≠ 0, also set `pc_err` to 1. It stays set until reset.
  3. `ValidBr`=1: pc + (sign-extended instr[15:0] << 2).
  4. Otherwise: pc + 4.
- All arithmetic is 32-bit modulo; overflow wraps silently.
- Base for the branch offset: `pc` already points at the instruction after the branch, because the fetch cycle incremented it. There is no delay slot.
- `jump` values 101–111 are treated as 000.
- `jump` ≠ 000 together with `ValidBr`=1: the jump wins.
- `pc_err` only sets when `PCWr`=1 and the jump is jr/jalr.
- `link` = `pc` (combinational), which is the address after the jal/jalr instruction.

## Timing
- Every register updates on the same edge as its enable. There is no wait state.
- Fetch cycle (`IRWr`=`PCWr`=1 with `jump`=000 and `ValidBr`=0):
  - `instr` captures the word addressed by the old `pc`.
  - `pc` becomes old `pc`+4.
- Branch and jump cycles: `PCWr`=1 with `IRWr`=0. The new `pc` is visible the cycle after the enable.
- `im_addr` and `link` follow `pc` combinationally, with zero latency.
- Reset mid-instruction: the next cycle shows the reset state. `instr_cnt` restarts at 0.
- `IRWr` with `PCWr`=0: only the IR and the counter change.

## Structure
- Shared header `head.v` holds:
  - the jump encodings (`Nojump`, J, JAL, JR, JALR);
  - the default `PC_RESET`.
- One combinational sub-module, `npc`, implements the next-PC selector. Inputs: `pc`, `instr`, `rs_data`, `jump`, `ValidBr`. Outputs: `npc` and `misalign`.
- `fetch_unit` holds the PC, IR, counter and sticky-flag registers.

## Test plan
- Reset, then 3 fetch cycles with `im_rdata` = A, B, C:
  - `pc` steps 3000 → 3004 → 3008 → 300C;
  - `instr` = C;
  - `instr_cnt` = 3.
- Taken branch backward: `pc`=3010, `instr`=0x1000FFFE, `ValidBr`=1, `PCWr`=1 → `pc`=3008. Repeat with `ValidBr`=0 and `PCWr`=0 → `pc` holds at 3010.
- j/jal: `pc`=3004, `instr[25:0]`=0x0000C10, `jump`=010, `PCWr`=1:
  - `link`=3004 before the edge;
  - `pc`=3040 after the edge.
- jr with misaligned target: `rs_data`=0x00003026, `jump`=011 → `pc`=3024 and `pc_err`=1. `pc_err` stays 1 across later fetches and clears only on `rst`.
- Conflicting and unused inputs:
  - `jump`=001 and `ValidBr`=1 together → jump target taken.
  - `jump`=111 → `pc`+4.
  - Branch from `pc`=FFFFFFFC with offset +1 → wraps to 0x00000000.
- `rst` asserted on a cycle with `PCWr`=`IRWr`=1 → the reset state is reached; no PC or IR update occurs and the counter does not increment.
